// File: rtl/mux_rr_nx.sv
// Registered N-channel mux with per-channel valid/ready handshakes,
// fixed-select or round-robin arbitration and a one-word output register.
module mux_rr_nx #(
    parameter int N     = 8,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             free;
    logic             sel_ok;
    logic             hit;
    logic [SEL_W-1:0] g;
    logic             grant;

    // First valid channel scanning ptr, ptr+1, ... with wrap; MSB = found.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [N-1:0]     v,
        input logic [SEL_W-1:0] p
    );
        logic [SEL_W:0] r;
        int             idx;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(p) + i;
            if (idx >= N) idx = idx - N;
            if (v[idx]) r = {1'b1, idx[SEL_W-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        free   = !out_valid_q || out_ready;
        sel_ok = {{(32-SEL_W){1'b0}}, select} < 32'(N);
        hit    = 1'b0;
        g      = '0;
        if (!mode) begin
            if (sel_ok && in_valid[select]) begin
                hit = 1'b1;
                g   = select;
            end
        end else begin
            {hit, g} = rr_pick(in_valid, ptr_q);
        end
        grant = !reset && free && hit;
    end

    always_comb begin
        in_ready = '0;
        if (grant) in_ready[g] = 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (free) begin
            if (hit) begin
                out_data_d  = in_data[g*W +: W];
                out_sel_d   = g;
                out_valid_d = 1'b1;
                if (mode) begin
                    ptr_d = (g == SEL_W'(N - 1)) ? '0 : g + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
